// File: rtl/vx_alu_dotp_if.sv
// Request/response bundle for the vx_alu_dotp packed dot-product unit.
// The master modport belongs to the requester; the unit takes the slave side.
interface vx_alu_dotp_if #(
    parameter int NUM_LANES = 1,
    parameter int XLEN      = 32,
    parameter int TAG_WIDTH = 8
);
    logic                      valid_in;
    logic                      ready_in;
    logic [3:0]                op_in;
    logic [NUM_LANES*XLEN-1:0] rs1_in;
    logic [NUM_LANES*XLEN-1:0] rs2_in;
    logic [NUM_LANES*XLEN-1:0] rs3_in;
    logic [TAG_WIDTH-1:0]      tag_in;
    logic                      valid_out;
    logic                      ready_out;
    logic [NUM_LANES*XLEN-1:0] data_out;
    logic [TAG_WIDTH-1:0]      tag_out;

    modport master (
        output valid_in, op_in, rs1_in, rs2_in, rs3_in, tag_in, ready_out,
        input  ready_in, valid_out, data_out, tag_out
    );

    modport slave (
        input  valid_in, op_in, rs1_in, rs2_in, rs3_in, tag_in, ready_out,
        output ready_in, valid_out, data_out, tag_out
    );
endinterface

// File: rtl/vx_alu_dotp.sv
// Iterative multi-lane packed int8/int16 dot product with optional rs3 accumulate.
// Define VX_DOTP_SAT_EN for a widened accumulator and a clamped final result.
module vx_alu_dotp #(
    parameter int NUM_LANES      = 1,
    parameter int XLEN           = 32,
    parameter int MACS_PER_CYCLE = 2,
    parameter int TAG_WIDTH      = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    vx_alu_dotp_if.slave    bus,
    output logic            busy
);
    localparam int N8      = XLEN / 8;
    localparam int N16     = XLEN / 16;
    localparam int BEATS8  = (N8 + MACS_PER_CYCLE - 1) / MACS_PER_CYCLE;
    localparam int BEATS16 = (N16 + MACS_PER_CYCLE - 1) / MACS_PER_CYCLE;
    localparam int CW      = $clog2(BEATS8 + 1) + 1;
`ifdef VX_DOTP_SAT_EN
    localparam int ACC_W   = XLEN + 8;
`else
    localparam int ACC_W   = XLEN;
`endif

    typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

    state_t                   state, state_nxt;
    logic                     accept, calc_en, finish, out_fire, ready_int;
    logic [CW-1:0]            beats;
    logic [CW-1:0]            cnt_q;
    logic [2:0]               op_q;
    logic [TAG_WIDTH-1:0]     tag_q;
    logic [XLEN-1:0]          rs1_q [NUM_LANES];
    logic [XLEN-1:0]          rs2_q [NUM_LANES];
    logic signed [ACC_W-1:0]  acc_q [NUM_LANES];

    // Sum of this beat's element products; elements past N contribute nothing.
    function automatic logic signed [ACC_W-1:0] beat_sum(
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b,
        input logic [2:0]      op,
        input logic [CW-1:0]   cnt
    );
        logic [2*XLEN-1:0]       a_w, b_w;
        logic signed [16:0]      ea, eb;
        logic signed [33:0]      prod;
        logic signed [ACC_W-1:0] sum;
        int                      base, ew, n;
        ew   = op[2] ? 16 : 8;
        n    = op[2] ? N16 : N8;
        base = int'(cnt) * MACS_PER_CYCLE;
        a_w  = {{XLEN{1'b0}}, a >> (base * ew)};
        b_w  = {{XLEN{1'b0}}, b >> (base * ew)};
        sum  = '0;
        for (int m = 0; m < MACS_PER_CYCLE; m++) begin
            if (op[2]) begin
                ea = {op[0] & a_w[m*16+15], a_w[m*16 +: 16]};
                eb = {op[1] & b_w[m*16+15], b_w[m*16 +: 16]};
            end else begin
                ea = {{9{op[0] & a_w[m*8+7]}}, a_w[m*8 +: 8]};
                eb = {{9{op[1] & b_w[m*8+7]}}, b_w[m*8 +: 8]};
            end
            prod = ea * eb;
            if (base + m < n)
                sum = sum + ACC_W'(prod);
        end
        return sum;
    endfunction

    function automatic logic signed [ACC_W-1:0] acc_seed(
        input logic [XLEN-1:0] rs3,
        input logic [3:0]      op
    );
        if (!op[3])
            return '0;
`ifdef VX_DOTP_SAT_EN
        if (op[0] | op[1])
            return ACC_W'($signed(rs3));
        return ACC_W'($unsigned(rs3));
`else
        return rs3;
`endif
    endfunction

`ifdef VX_DOTP_SAT_EN
    // Clamp to signed XLEN range in signed mode, else to [0, 2^XLEN-1].
    function automatic logic [XLEN-1:0] sat_result(
        input logic signed [ACC_W-1:0] acc,
        input logic                    is_signed
    );
        if (is_signed) begin
            if (acc[ACC_W-1:XLEN-1] == '0 || acc[ACC_W-1:XLEN-1] == '1)
                return acc[XLEN-1:0];
            return acc[ACC_W-1] ? {1'b1, {(XLEN-1){1'b0}}} : {1'b0, {(XLEN-1){1'b1}}};
        end
        if (acc[ACC_W-1])
            return '0;
        if (|acc[ACC_W-2:XLEN])
            return '1;
        return acc[XLEN-1:0];
    endfunction
`else
    function automatic logic [XLEN-1:0] sat_result(
        input logic signed [ACC_W-1:0] acc,
        input logic                    is_signed
    );
        logic unused;
        unused = is_signed;
        return acc;
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)   state_nxt = CALC;
            CALC:    if (finish)   state_nxt = OUT;
            OUT:     if (out_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        beats     = op_q[2] ? CW'(BEATS16) : CW'(BEATS8);
        ready_int = reset_n && (state == IDLE);
        accept    = ready_int && bus.valid_in;
        calc_en   = (state == CALC);
        finish    = calc_en && (cnt_q == beats);
        out_fire  = (state == OUT) && bus.ready_out;
        busy      = (state != IDLE);
    end

    assign bus.ready_in = ready_int;

    // Operand latch and per-lane accumulation; the cycle after the last beat only drains.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q  <= bus.op_in[2:0];
            tag_q <= bus.tag_in;
            cnt_q <= '0;
            for (int l = 0; l < NUM_LANES; l++) begin
                rs1_q[l] <= bus.rs1_in[l*XLEN +: XLEN];
                rs2_q[l] <= bus.rs2_in[l*XLEN +: XLEN];
                acc_q[l] <= acc_seed(bus.rs3_in[l*XLEN +: XLEN], bus.op_in);
            end
        end else if (calc_en && !finish) begin
            cnt_q <= cnt_q + 1'b1;
            for (int l = 0; l < NUM_LANES; l++)
                acc_q[l] <= acc_q[l] + beat_sum(rs1_q[l], rs2_q[l], op_q, cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.valid_out <= 1'b0;
            bus.data_out  <= '0;
            bus.tag_out   <= '0;
        end else if (finish) begin
            bus.valid_out <= 1'b1;
            bus.tag_out   <= tag_q;
            for (int l = 0; l < NUM_LANES; l++)
                bus.data_out[l*XLEN +: XLEN] <= sat_result(acc_q[l], op_q[0] | op_q[1]);
        end else if (out_fire) begin
            bus.valid_out <= 1'b0;
        end
    end
endmodule

// File: tb/tb_vx_alu_dotp.sv
// Directed-vector bench for vx_alu_dotp with two lanes and hand-computed results.
module tb_vx_alu_dotp;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic busy;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    vx_alu_dotp_if #(.NUM_LANES(2), .XLEN(32), .TAG_WIDTH(8)) bus ();

    vx_alu_dotp #(
        .NUM_LANES(2), .XLEN(32), .MACS_PER_CYCLE(2), .TAG_WIDTH(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic start(input logic [3:0] op,
                         input logic [31:0] a0, input logic [31:0] b0, input logic [31:0] c0,
                         input logic [31:0] a1, input logic [31:0] b1, input logic [31:0] c1,
                         input logic [7:0] tg);
        int w = 0;
        while (!bus.ready_in && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        chk("ready_before_issue", 64'(bus.ready_in), 64'd1);
        bus.op_in    = op;
        bus.rs1_in   = {a1, a0};
        bus.rs2_in   = {b1, b0};
        bus.rs3_in   = {c1, c0};
        bus.tag_in   = tg;
        bus.valid_in = 1'b1;
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        bus.op_in    = '0;
        bus.rs1_in   = '0;
        bus.rs2_in   = '0;
        bus.rs3_in   = '0;
        bus.tag_in   = '0;
    endtask

    task automatic collect(input string nm, input int lat_exp,
                           input logic [31:0] e0, input logic [31:0] e1, input logic [7:0] tg);
        int lat = 0;
        while (!bus.valid_out && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_latency"}, 64'(lat), 64'(lat_exp));
        chk({nm, "_lane0"}, 64'(bus.data_out[31:0]), 64'(e0));
        chk({nm, "_lane1"}, 64'(bus.data_out[63:32]), 64'(e1));
        chk({nm, "_tag"}, 64'(bus.tag_out), 64'(tg));
    endtask

    task automatic drain(input string nm);
        bus.ready_out = 1'b1;
        @(posedge clk); #1;
        bus.ready_out = 1'b0;
        chk({nm, "_vout_clr"}, 64'(bus.valid_out), 64'd0);
        chk({nm, "_ready_after"}, 64'(bus.ready_in), 64'd1);
    endtask

    initial begin
        int seen;
        bus.valid_in  = 1'b0;
        bus.ready_out = 1'b0;
        bus.op_in     = '0;
        bus.rs1_in    = '0;
        bus.rs2_in    = '0;
        bus.rs3_in    = '0;
        bus.tag_in    = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid_out", 64'(bus.valid_out), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready_in", 64'(bus.ready_in), 64'd0);
        chk("rst_data_out", 64'(bus.data_out), 64'd0);
        chk("rst_tag_out", 64'(bus.tag_out), 64'd0);
        reset_n = 1'b1;
        #1;
        chk("idle_ready_in", 64'(bus.ready_in), 64'd1);

        // Signed int8: lane0 squares of {1,-1,127,-128}; lane1 4*(2*3)
        start(4'b0011, 32'h01FF7F80, 32'h01FF7F80, 32'h0, 32'h02020202, 32'h03030303, 32'h0, 8'h11);
        chk("calc_busy", 64'(busy), 64'd1);
        chk("calc_ready_in", 64'(bus.ready_in), 64'd0);
        collect("s8", 3, 32'h00007F03, 32'h00000018, 8'h11);
        drain("s8");

        // Unsigned int8: 128^2+127^2+255^2+1; lane1 4*255
        start(4'b0000, 32'h01FF7F80, 32'h01FF7F80, 32'h0, 32'hFFFFFFFF, 32'h01010101, 32'h0, 8'h22);
        collect("u8", 3, 32'h00017D03, 32'h000003FC, 8'h22);
        drain("u8");

        // Signed int16 with accumulate: 2*4 + (-1)*3 + 10; lane1 3*5 + 2*(-1) + 256
        start(4'b1111, 32'hFFFF0002, 32'h00030004, 32'h0000000A,
              32'h00020003, 32'hFFFF0005, 32'h00000100, 8'h33);
        collect("s16acc", 2, 32'h0000000F, 32'h0000010D, 8'h33);
        drain("s16acc");

        // Mixed signedness, a signed / b unsigned: (-1)*255 and (-128)*2
        start(4'b0001, 32'h000000FF, 32'h000000FF, 32'h0, 32'h00000080, 32'h00000002, 32'h0, 8'h44);
        collect("mix8", 3, 32'hFFFFFF01, 32'hFFFFFF00, 8'h44);
        drain("mix8");

        // Mixed int16, b signed: 65535 * (-1)
        start(4'b0110, 32'h0000FFFF, 32'h0000FFFF, 32'h0, 32'h00010000, 32'h00050000, 32'h0, 8'h55);
        collect("mix16", 2, 32'hFFFF0001, 32'h00000005, 8'h55);
        drain("mix16");

        // Backpressure held in OUT for five cycles
        start(4'b0011, 32'h01FF7F80, 32'h01FF7F80, 32'h0, 32'h02020202, 32'h03030303, 32'h0, 8'h66);
        collect("bp", 3, 32'h00007F03, 32'h00000018, 8'h66);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid_out", 64'(bus.valid_out), 64'd1);
            chk("bp_data_out", 64'(bus.data_out), {32'h00000018, 32'h00007F03});
            chk("bp_tag_out", 64'(bus.tag_out), 64'h66);
            chk("bp_ready_in", 64'(bus.ready_in), 64'd0);
            chk("bp_busy", 64'(busy), 64'd1);
        end
        drain("bp");
        start(4'b1111, 32'hFFFF0002, 32'h00030004, 32'h0000000A,
              32'h00020003, 32'hFFFF0005, 32'h00000100, 8'h67);
        collect("b2b", 2, 32'h0000000F, 32'h0000010D, 8'h67);
        drain("b2b");

        // Reset pulse landing on beat 0 discards the operation
        start(4'b0011, 32'h01FF7F80, 32'h01FF7F80, 32'h0, 32'h02020202, 32'h03030303, 32'h0, 8'h77);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk("rstcalc_busy", 64'(busy), 64'd0);
        chk("rstcalc_valid_out", 64'(bus.valid_out), 64'd0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.valid_out) seen++;
        end
        chk("rstcalc_no_result", 64'(seen), 64'd0);
        start(4'b0000, 32'h01FF7F80, 32'h01FF7F80, 32'h0, 32'hFFFFFFFF, 32'h01010101, 32'h0, 8'h78);
        collect("after_rst", 3, 32'h00017D03, 32'h000003FC, 8'h78);
        drain("after_rst");

        // Overflow with accumulate; lane1 holds the signed minimum seed
        start(4'b1011, 32'h01FF7F80, 32'h01FF7F80, 32'h7FFFFFFF, 32'h0, 32'h0, 32'h80000000, 8'h88);
`ifdef VX_DOTP_SAT_EN
        collect("ovf", 3, 32'h7FFFFFFF, 32'h80000000, 8'h88);
`else
        collect("ovf", 3, 32'h80007F02, 32'h80000000, 8'h88);
`endif
        drain("ovf");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
